// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg
//  Shared types and constants for the idli memory controller.
//  Contents:
//   ctr_t       GCK phase counter type; one memory window spans ctr 0..3
//   mc_state_t  controller window state
//   mc_kind_t   what a redirect window sends as its address
//   MC_CNT_W    width of the setup window counter
//   MC_SETUP_RD windows from end of a redirect window to first read data window
//   MC_SETUP_WR windows from end of a redirect window to first write data window
// -----------------------------------------------------------------------------
package idli_pkg;

   typedef logic [1:0] ctr_t;

   typedef enum logic [1:0] {
      FETCH,
      REDIR,
      SETUP,
      LS_DATA
   } mc_state_t;

   typedef enum logic [1:0] {
      BR,
      LS,
      PC
   } mc_kind_t;

   localparam int unsigned MC_CNT_W = 3;

   // Both values must lie in 1..7: the setup counter never wraps.
   localparam logic [MC_CNT_W-1:0] MC_SETUP_RD = 3'd5;
   localparam logic [MC_CNT_W-1:0] MC_SETUP_WR = 3'd4;

endpackage : idli_pkg

// File: rtl/idli_mem_ctl_m.sv
// -----------------------------------------------------------------------------
// idli_mem_ctl_m
//  Schedules the shared SQI memory pair between the instruction fetch stream,
//  branch redirects and load/store requests, and drives the redirect,
//  write-enable, stall and slice inputs of idli_sqi_m. The memory works in
//  windows of four GCK cycles (i_mc_ctr 0..3); every state change takes effect
//  at a window boundary so the controller tracks the memory's phase exactly.
//
//  Ports
//   i_sqi_gck       core clock (2x SCK)
//   i_sqi_rst_n     asynchronous active-low reset
//   i_mc_ctr        GCK phase counter, 0 marks the first cycle of a window
//   i_mc_br_req     branch redirect request, held until o_mc_br_gnt
//   i_mc_br_slice   branch target nibble, little-endian, one per phase
//   i_mc_ls_req     load/store request, held until o_mc_ls_gnt
//   i_mc_ls_wr      1 = store, 0 = load
//   i_mc_ls_slice   load/store address nibble, one per phase
//   i_mc_st_slice   store data nibble, one per phase
//   i_mc_st_vld     store data available this window
//   i_mc_pc_slice   return PC nibble, sent after a load/store completes
//   o_mc_br_gnt     1-cycle pulse: branch accepted
//   o_mc_ls_gnt     1-cycle pulse: load/store accepted
//   o_mc_ls_done    1-cycle pulse: load data valid / store written
//   o_mc_fetch_vld  qualifies the memory's instruction-valid output
//   o_mc_redirect   to i_sqi_redirect
//   o_mc_wr_en      to i_sqi_wr_en
//   o_mc_stall      to i_sqi_stall
//   o_mc_slice      to i_sqi_slice: address or store data nibble
//   o_mc_redir_cnt  (IDLI_MEM_CTL_PERF_EN only) count of redirect windows
//
//  Configuration
//   IDLI_MEM_CTL_PERF_EN  when defined, adds the 16-bit o_mc_redir_cnt
//                         counter of redirect windows (wraps, resets to 0).
// -----------------------------------------------------------------------------
module idli_mem_ctl_m
   import idli_pkg::*;
#(
   parameter logic [MC_CNT_W-1:0] SETUP_RD = MC_SETUP_RD,
   parameter logic [MC_CNT_W-1:0] SETUP_WR = MC_SETUP_WR
) (
   input  logic       i_sqi_gck,
   input  logic       i_sqi_rst_n,
   input  ctr_t       i_mc_ctr,
   input  logic       i_mc_br_req,
   input  logic [3:0] i_mc_br_slice,
   input  logic       i_mc_ls_req,
   input  logic       i_mc_ls_wr,
   input  logic [3:0] i_mc_ls_slice,
   input  logic [3:0] i_mc_st_slice,
   input  logic       i_mc_st_vld,
   input  logic [3:0] i_mc_pc_slice,
   output logic       o_mc_br_gnt,
   output logic       o_mc_ls_gnt,
   output logic       o_mc_ls_done,
   output logic       o_mc_fetch_vld,
   output logic       o_mc_redirect,
   output logic       o_mc_wr_en,
   output logic       o_mc_stall,
   output logic [3:0] o_mc_slice
`ifdef IDLI_MEM_CTL_PERF_EN
  ,output logic [15:0] o_mc_redir_cnt
`endif
);

   mc_state_t           state_q;
   mc_kind_t            kind_q;       // kind of the current/last redirect
   mc_kind_t            pend_kind_q;  // kind accepted at this window's start
   logic                pend_q;       // a request was granted in this FETCH window
   logic                pend_wr_q;    // granted request is a store
   logic [MC_CNT_W-1:0] cnt_q;        // setup windows remaining
   logic                wr_en_q;      // held from one redirect to the next
   logic                stall_q;      // store data missing for this window

   logic win_start;
   logic win_end;
   logic stall_now;

   assign win_start = (i_mc_ctr == 2'd0);
   assign win_end   = (i_mc_ctr == 2'd3);

   // A grant is taken at the first cycle of a FETCH window, but the state only
   // moves at the window's last cycle so the redirect window lines up with
   // ctr 0..3. The request kind is parked in pend_* for the rest of the window
   // because the requester drops its request once granted.
   // NOTE: sequential state uses non-blocking assignments only; every register
   // here, including the pending-request holding registers, gets a reset value
   // so a reset mid-operation discards any grant in flight.
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state_q     <= FETCH;
         kind_q      <= BR;
         pend_kind_q <= BR;
         pend_q      <= 1'b0;
         pend_wr_q   <= 1'b0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (win_start) begin
                  if (i_mc_br_req) begin
                     pend_q      <= 1'b1;
                     pend_kind_q <= BR;
                     pend_wr_q   <= 1'b0;
                  end else if (i_mc_ls_req) begin
                     pend_q      <= 1'b1;
                     pend_kind_q <= LS;
                     pend_wr_q   <= i_mc_ls_wr;
                  end
               end
               if (win_end && pend_q) begin
                  state_q <= REDIR;
                  kind_q  <= pend_kind_q;
                  wr_en_q <= pend_wr_q;
                  pend_q  <= 1'b0;
               end
            end

            REDIR: begin
               if (win_end) begin
                  state_q <= SETUP;
                  cnt_q   <= wr_en_q ? SETUP_WR : SETUP_RD;
               end
            end

            SETUP: begin
               if (win_end) begin
                  if (cnt_q == MC_CNT_W'(1)) begin
                     state_q <= (kind_q == LS) ? LS_DATA : FETCH;
                  end else begin
                     cnt_q <= cnt_q - MC_CNT_W'(1);
                  end
               end
            end

            LS_DATA: begin
               // A store without data stalls the memory for the whole window
               // and the data window is retried.
               if (win_start) begin
                  stall_q <= wr_en_q && !i_mc_st_vld;
               end
               if (win_end && !stall_q) begin
                  state_q <= REDIR;
                  kind_q  <= PC;
                  wr_en_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // At ctr 0 the stall decision is not yet registered, so it is taken from
   // st_vld directly; for ctr 1..3 the registered decision holds it steady.
   assign stall_now = (state_q == LS_DATA) && wr_en_q &&
                      (win_start ? !i_mc_st_vld : stall_q);

   // Outputs decode the registered window state against the phase counter so
   // they line up with ctr 0..3 of the memory window they belong to.
   assign o_mc_br_gnt    = (state_q == FETCH) && win_start && i_mc_br_req;
   assign o_mc_ls_gnt    = (state_q == FETCH) && win_start && !i_mc_br_req && i_mc_ls_req;
   assign o_mc_ls_done   = (state_q == LS_DATA) && win_end && !stall_now;
   assign o_mc_fetch_vld = (state_q == FETCH);
   assign o_mc_redirect  = (state_q == REDIR);
   assign o_mc_wr_en     = wr_en_q;
   assign o_mc_stall     = stall_now;

   // NOTE: the combinational mux assigns a default first so no path can hold
   // the previous value and infer a latch.
   always_comb begin
      o_mc_slice = 4'h0;
      if (state_q == REDIR) begin
         unique case (kind_q)
            BR:      o_mc_slice = i_mc_br_slice;
            LS:      o_mc_slice = i_mc_ls_slice;
            default: o_mc_slice = i_mc_pc_slice;
         endcase
      end else if ((state_q == LS_DATA) && wr_en_q && !stall_now) begin
         o_mc_slice = i_mc_st_slice;
      end
   end

`ifdef IDLI_MEM_CTL_PERF_EN
   logic [15:0] redir_cnt_q;

   // Counted on the first cycle of each redirect window; wraps naturally.
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         redir_cnt_q <= '0;
      end else if ((state_q == REDIR) && win_start) begin
         redir_cnt_q <= redir_cnt_q + 16'd1;
      end
   end

   assign o_mc_redir_cnt = redir_cnt_q;
`endif

endmodule : idli_mem_ctl_m

// File: tb/tb_idli_mem_ctl_m.sv
// -----------------------------------------------------------------------------
// tb_idli_mem_ctl_m
//  Self-checking bench for idli_mem_ctl_m. Expected behaviour is described as
//  a list of whole memory windows (what each window must show on the outputs),
//  built from the controller's scheduling rules; every GCK cycle is compared
//  against the window it belongs to.
// -----------------------------------------------------------------------------
module tb_idli_mem_ctl_m;

   logic       gck = 1'b0;
   logic       rst_n;
   logic [1:0] ctr;
   logic       br_req, ls_req, ls_wr, st_vld;
   logic [3:0] br_slice, ls_slice, st_slice, pc_slice;
   logic       br_gnt, ls_gnt, ls_done, fetch_vld, redirect, wr_en, stall;
   logic [3:0] slice;
`ifdef IDLI_MEM_CTL_PERF_EN
   logic [15:0] redir_cnt;
`endif

   idli_mem_ctl_m dut (
      .i_sqi_gck      (gck),
      .i_sqi_rst_n    (rst_n),
      .i_mc_ctr       (ctr),
      .i_mc_br_req    (br_req),
      .i_mc_br_slice  (br_slice),
      .i_mc_ls_req    (ls_req),
      .i_mc_ls_wr     (ls_wr),
      .i_mc_ls_slice  (ls_slice),
      .i_mc_st_slice  (st_slice),
      .i_mc_st_vld    (st_vld),
      .i_mc_pc_slice  (pc_slice),
      .o_mc_br_gnt    (br_gnt),
      .o_mc_ls_gnt    (ls_gnt),
      .o_mc_ls_done   (ls_done),
      .o_mc_fetch_vld (fetch_vld),
      .o_mc_redirect  (redirect),
      .o_mc_wr_en     (wr_en),
      .o_mc_stall     (stall),
      .o_mc_slice     (slice)
`ifdef IDLI_MEM_CTL_PERF_EN
     ,.o_mc_redir_cnt (redir_cnt)
`endif
   );

   always #5 gck = ~gck;

   // One expected memory window.
   typedef struct {
      logic        fv;    // fetch_vld
      logic        rd;    // redirect
      logic        wr;    // wr_en
      logic        st;    // stall
      logic        done;  // ls_done pulse at ctr 3
      logic        gbr;   // br_gnt pulse at ctr 0
      logic        gls;   // ls_gnt pulse at ctr 0
      logic        stv;   // st_vld driven during this window
      logic [15:0] sl;    // expected slice nibbles, ctr 0 = bits 3:0
   } win_t;

   win_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        m_wr;        // write-enable level set by the last redirect
   int          m_redirs;    // redirect windows since reset
   logic [15:0] tgt, addr, sdata, pc;

   // ---------------------------------------------------------------- model
   function automatic win_t blank_win();
      win_t w;
      w.fv = 1'b0; w.rd = 1'b0; w.wr = m_wr; w.st = 1'b0; w.done = 1'b0;
      w.gbr = 1'b0; w.gls = 1'b0; w.stv = 1'($urandom); w.sl = 16'h0;
      return w;
   endfunction

   task automatic push_fetch(input logic gbr, input logic gls);
      win_t w = blank_win();
      w.fv = 1'b1; w.gbr = gbr; w.gls = gls;
      exp_q.push_back(w);
   endtask

   task automatic push_redir(input logic [15:0] sl, input logic wr);
      win_t w;
      m_wr = wr;
      m_redirs++;
      w = blank_win();
      w.rd = 1'b1; w.sl = sl;
      exp_q.push_back(w);
   endtask

   task automatic push_setup();
      int n = m_wr ? 4 : 5;
      for (int i = 0; i < n; i++) exp_q.push_back(blank_win());
   endtask

   task automatic push_br();
      push_redir(tgt, 1'b0);
      push_setup();
   endtask

   // Full load/store: address redirect, setup, data (with stalls), PC redirect.
   task automatic push_ls(input logic store, input int stalls);
      win_t w;
      push_redir(addr, store);
      push_setup();
      if (store) begin
         for (int i = 0; i < stalls; i++) begin
            w = blank_win();
            w.st = 1'b1; w.stv = 1'b0;
            exp_q.push_back(w);
         end
      end
      w = blank_win();
      w.done = 1'b1; w.stv = 1'b1; w.sl = store ? sdata : 16'h0;
      exp_q.push_back(w);
      push_redir(pc, 1'b0);
      push_setup();
   endtask

   // ------------------------------------------------------------- checking
   task automatic run_all(input string tag);
      win_t       e;
      logic [10:0] exp_v, act_v;
      int          n = exp_q.size();
      for (int w = 0; w < n; w++) begin
         e = exp_q.pop_front();
         for (int p = 0; p < 4; p++) begin
            @(posedge gck);
            #1;
            ctr = 2'(p);
            if (p == 0) st_vld = e.stv;
            if (p == 1) begin
               if (e.gbr) br_req = 1'b0;
               if (e.gls) ls_req = 1'b0;
            end
            br_slice = tgt[4*p +: 4];
            ls_slice = addr[4*p +: 4];
            st_slice = sdata[4*p +: 4];
            pc_slice = pc[4*p +: 4];
            @(negedge gck);
            exp_v = {(p == 0) && e.gbr, (p == 0) && e.gls, (p == 3) && e.done,
                     e.fv, e.rd, e.wr, e.st, e.sl[4*p +: 4]};
            act_v = {br_gnt, ls_gnt, ls_done, fetch_vld, redirect, wr_en, stall, slice};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL %s win %0d ctr %0d: {brg,lsg,done,fv,rd,wr,st,slice} got %b want %b",
                        tag, w, p, act_v, exp_v);
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [10:0] act_v;
      act_v = {br_gnt, ls_gnt, ls_done, fetch_vld, redirect, wr_en, stall, slice};
      checks++;
      if (act_v !== 11'b000_1000_0000) begin
         errors++;
         $display("FAIL %s: outputs got %b want %b", tag, act_v, 11'b000_1000_0000);
      end
   endtask

   // Releases reset with ctr at 3 so the next cycle starts a fresh window.
   task automatic release_reset();
      @(posedge gck);
      #1;
      ctr   = 2'd3;
      rst_n = 1'b1;
      m_wr  = 1'b0;
      m_redirs = 0;
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      ctr = 2'd3; br_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; st_vld = 1'b0;
      br_slice = 4'h0; ls_slice = 4'h0; st_slice = 4'h0; pc_slice = 4'h0;
      tgt = 16'h0; addr = 16'h0; sdata = 16'h0; pc = 16'h0;
      repeat (2) @(negedge gck);
      check_reset_outputs("reset_values");
      release_reset();
      for (int i = 0; i < 8; i++) push_fetch(1'b0, 1'b0);
      run_all("idle_after_reset");
   endtask

   task automatic test_branch();
      tgt = 16'h1234;
      br_req = 1'b1;
      push_fetch(1'b1, 1'b0);
      push_br();
      push_fetch(1'b0, 1'b0);
      push_fetch(1'b0, 1'b0);
      run_all("branch");
   endtask

   task automatic test_load();
      addr = 16'h00A5; pc = 16'h0010;
      ls_wr = 1'b0; ls_req = 1'b1;
      push_fetch(1'b0, 1'b1);
      push_ls(1'b0, 0);
      push_fetch(1'b0, 1'b0);
      run_all("load");
   endtask

   task automatic test_store();
      addr = 16'h0F00; sdata = 16'hBEEF; pc = 16'h0024;
      ls_wr = 1'b1; ls_req = 1'b1;
      push_fetch(1'b0, 1'b1);
      push_ls(1'b1, 2);
      push_fetch(1'b0, 1'b0);
      run_all("store_stall");
   endtask

   task automatic test_both_req();
      logic st = 1'b1;
      tgt = 16'h4C2E; addr = 16'h7311; sdata = 16'h9A5D; pc = 16'h0150;
      ls_wr = st; br_req = 1'b1; ls_req = 1'b1;
      push_fetch(1'b1, 1'b0);
      push_br();
      push_fetch(1'b0, 1'b1);
      push_ls(st, 1);
      push_fetch(1'b0, 1'b0);
      run_all("branch_over_ls");
   endtask

   task automatic test_random();
      int op, stalls, idle;
      for (int it = 0; it < 10; it++) begin
         tgt   = 16'($urandom);
         addr  = 16'($urandom);
         sdata = 16'($urandom);
         pc    = 16'($urandom);
         op     = $urandom_range(0, 3);
         stalls = $urandom_range(0, 3);
         idle   = $urandom_range(0, 2);
         for (int i = 0; i < idle; i++) push_fetch(1'b0, 1'b0);
         if (op == 0) begin
            br_req = 1'b1;
            push_fetch(1'b1, 1'b0);
            push_br();
         end else if (op == 3) begin
            ls_wr = 1'($urandom);
            br_req = 1'b1; ls_req = 1'b1;
            push_fetch(1'b1, 1'b0);
            push_br();
            push_fetch(1'b0, 1'b1);
            push_ls(ls_wr, stalls);
         end else begin
            ls_wr = (op == 2);
            ls_req = 1'b1;
            push_fetch(1'b0, 1'b1);
            push_ls(ls_wr, stalls);
         end
         push_fetch(1'b0, 1'b0);
         // Requests are raised only once the idle windows have passed.
         if (idle > 0) begin
            logic hb = br_req, hl = ls_req;
            win_t keep[$];
            br_req = 1'b0; ls_req = 1'b0;
            for (int i = 0; i < idle; i++) keep.push_back(exp_q.pop_front());
            for (int i = idle - 1; i >= 0; i--) exp_q.push_front(keep[i]);
            begin
               win_t rest[$];
               rest = exp_q[idle:$];
               exp_q = exp_q[0:idle-1];
               run_all("random_idle");
               br_req = hb; ls_req = hl;
               exp_q = rest;
            end
         end
         run_all("random");
      end
`ifdef IDLI_MEM_CTL_PERF_EN
      checks++;
      if (redir_cnt !== 16'(m_redirs)) begin
         errors++;
         $display("FAIL redir_cnt: got %0d want %0d", redir_cnt, m_redirs);
      end
`endif
   endtask

   task automatic test_reset_mid_store();
      addr = 16'h0F00; sdata = 16'h1357; pc = 16'h0040;
      ls_wr = 1'b1; ls_req = 1'b1;
      push_fetch(1'b0, 1'b1);
      push_redir(addr, 1'b1);
      exp_q.push_back(blank_win());
      exp_q.push_back(blank_win());
      run_all("store_before_reset");
      @(posedge gck);
      #1;
      ctr = 2'd0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_setup");
      repeat (3) @(posedge gck);
      release_reset();
      #1;
      check_reset_outputs("reset_release");
      for (int i = 0; i < 3; i++) push_fetch(1'b0, 1'b0);
      run_all("fetch_after_mid_reset");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_branch();
      test_load();
      test_store();
      test_both_req();
      test_random();
      test_reset_mid_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_idli_mem_ctl_m
